assoc_cache: RTL and testbench

- Parametrised N-way set-associative, write-back, write-allocate data cache with an integrated miss controller.
- Generalises the direct-mapped line store to configurable ways, sets and line length, and adds dirty tracking, true-LRU replacement and valid/ready handshakes on the processor side and the line-wide memory side.
- Sits between the core load/store unit and main memory.

---
 rtl/assoc_cache.sv | 208 ++++++++++++++++++++
 tb/tb_assoc_cache.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_cache.sv
// N-way set-associative write-back, write-allocate data cache with miss FSM.
// Ports: clk/reset_n, processor req/resp handshake, line-wide memory req/resp.
module assoc_cache #(
  parameter int WAYS       = 2,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4,
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 10
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_we,
  input  logic [ADDR_W-1:0]                    req_addr,
  input  logic [WORD_W-1:0]                    req_wdata,
  output logic                                 resp_valid,
  output logic [WORD_W-1:0]                    resp_rdata,
  output logic                                 mem_req_valid,
  input  logic                                 mem_req_ready,
  output logic                                 mem_req_we,
  output logic [ADDR_W-$clog2(LINE_WORDS)-1:0] mem_req_addr,
  output logic [LINE_WORDS*WORD_W-1:0]         mem_wdata,
  input  logic                                 mem_resp_valid,
  input  logic [LINE_WORDS*WORD_W-1:0]         mem_rdata
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_W = LINE_WORDS * WORD_W;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WB,
    REFILL,
    FILL_WAIT
  } state_t;

  state_t state_q, state_d;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WAY_W-1:0]  vic_q;

  logic              vld  [WAYS][SETS];
  logic              drt  [WAYS][SETS];
  logic [WAY_W-1:0]  age  [WAYS][SETS];
  logic [TAG_W-1:0]  tags [WAYS][SETS];
  logic [LINE_W-1:0] data [WAYS][SETS];

  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q;
  logic [OFF_W-1:0] off_q;

  assign tag_q = addr_q[ADDR_W-1 -: TAG_W];
  assign idx_q = addr_q[OFF_W +: IDX_W];
  assign off_q = addr_q[OFF_W-1:0];

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             vic_found;
  logic [WAY_W-1:0] vic_way;
  logic             vic_dirty;
  logic [LINE_W-1:0] hit_line;
  logic [WORD_W-1:0] hit_word;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (vld[w][idx_q] && tags[w][idx_q] == tag_q) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest invalid way wins (descending scan); else the oldest way.
  always_comb begin
    vic_found = 1'b0;
    vic_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!vld[w][idx_q]) begin
        vic_found = 1'b1;
        vic_way   = WAY_W'(w);
      end
    end
    if (!vic_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age[w][idx_q] == WAY_W'(WAYS - 1))
          vic_way = WAY_W'(w);
      end
    end
  end

  assign vic_dirty = vld[vic_way][idx_q] && drt[vic_way][idx_q];
  assign hit_line  = data[hit_way][idx_q];
  assign hit_word  = hit_line[off_q*WORD_W +: WORD_W];

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_wdata     = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_d = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          resp_valid = 1'b1;
          if (!we_q)
            resp_rdata = hit_word;
          state_d = IDLE;
        end else if (vic_dirty) begin
          state_d = WB;
        end else begin
          state_d = REFILL;
        end
      end
      WB: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {tags[vic_q][idx_q], idx_q};
        mem_wdata     = data[vic_q][idx_q];
        if (mem_req_ready)
          state_d = REFILL;
      end
      REFILL: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {tag_q, idx_q};
        if (mem_req_ready)
          state_d = FILL_WAIT;
      end
      FILL_WAIT: begin
        if (mem_resp_valid)
          state_d = COMPARE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      vic_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == COMPARE && !hit)
        vic_q <= vic_way;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          vld[w][s] <= 1'b0;
          drt[w][s] <= 1'b0;
          age[w][s] <= WAY_W'(w);
        end
      end
    end else begin
      if (state_q == COMPARE && hit) begin
        for (int w = 0; w < WAYS; w++) begin
          if (age[w][idx_q] < age[hit_way][idx_q])
            age[w][idx_q] <= WAY_W'(age[w][idx_q] + 1'b1);
        end
        age[hit_way][idx_q] <= '0;
        if (we_q)
          drt[hit_way][idx_q] <= 1'b1;
      end
      if (state_q == FILL_WAIT && mem_resp_valid) begin
        vld[vic_q][idx_q] <= 1'b1;
        drt[vic_q][idx_q] <= 1'b0;
      end
    end
  end

  // Line storage needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (state_q == COMPARE && hit && we_q)
      data[hit_way][idx_q][off_q*WORD_W +: WORD_W] <= wdata_q;
    if (state_q == FILL_WAIT && mem_resp_valid) begin
      data[vic_q][idx_q] <= mem_rdata;
      tags[vic_q][idx_q] <= tag_q;
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Scoreboard bench for assoc_cache: directed loads/stores, memory model,
// response and memory-request queues checked by separate processes.
`timescale 1ns/1ps
module tb_assoc_cache;

  localparam int AW = 10;
  localparam int WW = 32;
  localparam int LA = 8;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [WW-1:0] req_wdata;
  logic          resp_valid;
  logic [WW-1:0] resp_rdata;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_we;
  logic [LA-1:0] mem_req_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_resp_valid;
  logic [LW-1:0] mem_rdata;

  assoc_cache #(
    .WAYS(2), .SETS(16), .LINE_WORDS(4), .WORD_W(WW), .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr),
    .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [LA-1:0] addr;
    logic [LW-1:0] line;
  } mreq_t;

  int n_cmp = 0;
  int n_bad = 0;
  int n_mreq = 0;
  int stall_wb = 0;
  bit hold_resp = 1'b0;

  mreq_t         exp_m[$];
  logic [WW-1:0] exp_r[$];
  logic [LW-1:0] mem_arr [256];

  task automatic chk(input string name, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_m(input logic we, input logic [LA-1:0] a,
                        input logic [LW-1:0] l);
    mreq_t m;
    m.we = we;
    m.addr = a;
    m.line = l;
    exp_m.push_back(m);
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (reset_n && resp_valid) begin
      if (exp_r.size() == 0)
        chk("resp_unexpected", 1, 0);
      else
        chk("resp_rdata", resp_rdata, exp_r.pop_front());
    end
  end

  // Memory model and memory-request checker
  initial begin
    mreq_t         e;
    logic          m_we;
    logic [LA-1:0] m_addr;
    logic [LW-1:0] m_wd;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    forever begin
      @(negedge clk);
      if (reset_n && mem_req_valid) begin
        m_we   = mem_req_we;
        m_addr = mem_req_addr;
        m_wd   = mem_wdata;
        if (m_we && stall_wb > 0) begin
          for (int i = 0; i < stall_wb; i++) begin
            @(negedge clk);
            chk("stall_valid", mem_req_valid, 1);
            chk("stall_we", mem_req_we, m_we);
            chk("stall_addr", mem_req_addr, m_addr);
            chk("stall_wdata", mem_wdata, m_wd);
            chk("stall_req_ready", req_ready, 0);
          end
          stall_wb = 0;
        end
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1 mem_req_ready = 1'b0;
        n_mreq++;
        if (exp_m.size() == 0) begin
          chk("mreq_unexpected", 1, 0);
        end else begin
          e = exp_m.pop_front();
          chk("mreq_we", m_we, e.we);
          chk("mreq_addr", m_addr, e.addr);
          if (e.we)
            chk("mreq_wdata", m_wd, e.line);
        end
        if (m_we) begin
          mem_arr[m_addr] = m_wd;
        end else begin
          chk("mreq_drop", mem_req_valid, 0);
          if (!hold_resp) begin
            @(negedge clk);
            mem_resp_valid = 1'b1;
            mem_rdata = mem_arr[m_addr];
            @(posedge clk);
            #1;
            mem_resp_valid = 1'b0;
            mem_rdata = '0;
          end
        end
      end
    end
  end

  task automatic req(input logic we, input logic [AW-1:0] a,
                     input logic [WW-1:0] d, input logic [WW-1:0] exp,
                     input bit is_hit, input bit want_resp);
    int n0;
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1'b1;
    end
    if (!got) begin
      chk("req_ready_timeout", 0, 1);
      return;
    end
    if (want_resp) exp_r.push_back(exp);
    n0 = n_mreq;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (is_hit) begin
      @(negedge clk);
      chk("hit_latency", resp_valid, 1);
      chk("hit_no_mem", n_mreq, n0);
    end
    if (want_resp) begin
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
        if (exp_r.size() == 0) got = 1'b1;
        else @(negedge clk);
      end
      if (!got) chk("resp_timeout", 0, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    int n0;
    for (int l = 0; l < 256; l++)
      for (int i = 0; i < 4; i++)
        mem_arr[l][i*WW +: WW] = {8'hC0, 8'(l), 8'h00, 8'(i)};
    mem_arr[8'h04] = {32'hD, 32'hC, 32'hB, 32'hA};

    reset_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_mem_we", mem_req_we, 0);
    chk("rst_mem_addr", mem_req_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    reset_n = 1'b1;

    // Cold load, then hit in the same line
    push_m(1'b0, 8'h04, '0);
    req(1'b0, 10'h013, 0, 32'hD, 0, 1);
    req(1'b0, 10'h010, 0, 32'hA, 1, 1);

    // Store hit, then read back
    req(1'b1, 10'h011, 32'hDEADBEEF, 32'h0, 1, 1);
    req(1'b0, 10'h011, 0, 32'hDEADBEEF, 1, 1);

    // Clean LRU eviction of tag 1
    push_m(1'b0, 8'h14, '0);
    req(1'b0, 10'h053, 0, 32'hC0140003, 0, 1);
    req(1'b0, 10'h013, 0, 32'hD, 1, 1);
    push_m(1'b0, 8'h24, '0);
    req(1'b0, 10'h093, 0, 32'hC0240003, 0, 1);
    req(1'b0, 10'h013, 0, 32'hD, 1, 1);

    // Dirty writeback with a stalled handshake
    push_m(1'b0, 8'h14, '0);
    req(1'b1, 10'h050, 32'h55, 32'h0, 0, 1);
    req(1'b0, 10'h013, 0, 32'hD, 1, 1);
    stall_wb = 5;
    push_m(1'b1, 8'h14,
           {32'hC0140003, 32'hC0140002, 32'hC0140001, 32'h00000055});
    push_m(1'b0, 8'h24, '0);
    req(1'b0, 10'h093, 0, 32'hC0240003, 0, 1);
    chk("wb_mem_word0", mem_arr[8'h14][31:0], 32'h55);

    // Reset while waiting for refill data
    hold_resp = 1'b1;
    n0 = n_mreq;
    push_m(1'b0, 8'h08, '0);
    req(1'b0, 10'h020, 0, 0, 0, 0);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (n_mreq != n0) got = 1'b1;
    end
    if (!got) chk("fill_wait_timeout", 0, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_fw_mem_valid", mem_req_valid, 0);
    chk("rst_fw_req_ready", req_ready, 1);
    chk("rst_fw_resp_valid", resp_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    hold_resp = 1'b0;
    push_m(1'b0, 8'h04, '0);
    req(1'b0, 10'h010, 0, 32'hA, 0, 1);

    repeat (5) @(negedge clk);
    chk("mreq_left", exp_m.size(), 0);
    chk("resp_left", exp_r.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
